// File: rtl/pwm_cfg_sequencer_if.sv
// Register bus between the PS and the PWM configuration sequencer:
// a single-cycle write strobe and a read port with registered data.
interface pwm_cfg_sequencer_if;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// Shadowed period/duty configuration for the 8-channel PWM: commits on a
// period boundary, then slews each channel's duty toward its target once per period.
module pwm_cfg_sequencer #(
    parameter int          NUM_CH   = 8,
    parameter logic [31:0] DEF_FREQ = 32'd9999
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    pwm_cfg_sequencer_if.slave   bus,
    input  logic                 period_tick,
    output logic [31:0]          FREQ_Cnt_Set,
    output logic [31:0]          CH0_duty_Set,
    output logic [31:0]          CH1_duty_Set,
    output logic [31:0]          CH2_duty_Set,
    output logic [31:0]          CH3_duty_Set,
    output logic [31:0]          CH4_duty_Set,
    output logic [31:0]          CH5_duty_Set,
    output logic [31:0]          CH6_duty_Set,
    output logic [31:0]          CH7_duty_Set,
    output logic                 busy
);

    logic [31:0]                   freq_sh_q, freq_q, step_q, rd_data_q, rd_data_d;
    logic                          enable_q, pending_q, pending_d;
    logic [NUM_CH-1:0][31:0]       tgt_sh_q, tgt_q, tgt_d, duty_q, duty_d;
    logic                          commit_wr, commit_fire;
    logic [NUM_CH-1:0]             ch_off;

    assign commit_wr   = bus.wr_en && (bus.wr_addr == 4'h2) && bus.wr_data[1];
    assign commit_fire = period_tick && pending_q;
    // A commit written on the tick itself waits for the next tick.
    assign pending_d   = commit_wr || (pending_q && !period_tick);

    // Next duty moves toward the target by at most step; step 0 means jump.
    function automatic logic [31:0] ramp(input logic [31:0] cur,
                                         input logic [31:0] tgt,
                                         input logic [31:0] stp);
        logic [31:0] res;
        res = cur;
        if (stp == 32'd0)
            res = tgt;
        else if (cur < tgt)
            res = cur + (((tgt - cur) < stp) ? (tgt - cur) : stp);
        else if (cur > tgt)
            res = cur - (((cur - tgt) < stp) ? (cur - tgt) : stp);
        return res;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign tgt_d[i]  = commit_fire ? tgt_sh_q[i] : tgt_q[i];
        assign duty_d[i] = enable_q ? ramp(duty_q[i], tgt_d[i], step_q) : 32'd0;
        assign ch_off[i] = duty_q[i] != (enable_q ? tgt_q[i] : 32'd0);
    end

    assign busy = pending_q || (|ch_off);

    always_comb begin
        rd_data_d = 32'd0;
        case (bus.rd_addr)
            4'h0:    rd_data_d = freq_sh_q;
            4'h1:    rd_data_d = step_q;
            4'h2:    rd_data_d = {29'd0, busy, pending_q, enable_q};
            4'h3:    rd_data_d = freq_q;
            4'h4, 4'h5, 4'h6, 4'h7:
                     rd_data_d = duty_q[{1'b0, bus.rd_addr[1:0]}];
            default: rd_data_d = tgt_sh_q[bus.rd_addr[2:0]];
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            freq_sh_q <= DEF_FREQ;
            freq_q    <= DEF_FREQ;
            step_q    <= 32'd0;
            enable_q  <= 1'b0;
            pending_q <= 1'b0;
            tgt_sh_q  <= '0;
            tgt_q     <= '0;
            duty_q    <= '0;
            rd_data_q <= 32'd0;
        end else begin
            pending_q <= pending_d;
            rd_data_q <= rd_data_d;
            if (bus.wr_en) begin
                case (bus.wr_addr)
                    4'h0: freq_sh_q <= bus.wr_data;
                    4'h1: step_q    <= bus.wr_data;
                    4'h2: enable_q  <= bus.wr_data[0];
                    4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF:
                          tgt_sh_q[bus.wr_addr[2:0]] <= bus.wr_data;
                    default: ;
                endcase
            end
            if (commit_fire) begin
                freq_q <= freq_sh_q;
                tgt_q  <= tgt_sh_q;
            end
            if (period_tick)
                duty_q <= duty_d;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign FREQ_Cnt_Set  = freq_q;
    assign CH0_duty_Set  = duty_q[0];
    assign CH1_duty_Set  = duty_q[1];
    assign CH2_duty_Set  = duty_q[2];
    assign CH3_duty_Set  = duty_q[3];
    assign CH4_duty_Set  = duty_q[4];
    assign CH5_duty_Set  = duty_q[5];
    assign CH6_duty_Set  = duty_q[6];
    assign CH7_duty_Set  = duty_q[7];

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer: per-cycle vector table plus
// hand-written readback and asynchronous-reset sequences.
module tb_pwm_cfg_sequencer;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        period_tick = 1'b0;
    logic [31:0] FREQ_Cnt_Set;
    logic [31:0] ch_out [8];
    logic        busy;
    int          n_chk = 0;
    int          n_pass = 0;

    pwm_cfg_sequencer_if bus ();

    pwm_cfg_sequencer dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .bus          (bus.slave),
        .period_tick  (period_tick),
        .FREQ_Cnt_Set (FREQ_Cnt_Set),
        .CH0_duty_Set (ch_out[0]),
        .CH1_duty_Set (ch_out[1]),
        .CH2_duty_Set (ch_out[2]),
        .CH3_duty_Set (ch_out[3]),
        .CH4_duty_Set (ch_out[4]),
        .CH5_duty_Set (ch_out[5]),
        .CH6_duty_Set (ch_out[6]),
        .CH7_duty_Set (ch_out[7]),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [3:0]  a;
        logic [31:0] d;
        logic        tk;
        int          ch;
        logic [31:0] ef;
        logic [31:0] ed;
        logic        eb;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic we, logic [3:0] a, logic [31:0] d, logic tk,
                                int ch, logic [31:0] ef, logic [31:0] ed, logic eb);
        vec_t v;
        v.we = we; v.a = a; v.d = d; v.tk = tk;
        v.ch = ch; v.ef = ef; v.ed = ed; v.eb = eb;
        vq.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive one cycle's inputs at the negedge, sample just after the posedge.
    task automatic cycle(logic we, logic [3:0] a, logic [31:0] d, logic tk);
        @(negedge CLK);
        bus.wr_en = we; bus.wr_addr = a; bus.wr_data = d; period_tick = tk;
        @(posedge CLK);
        #1;
        bus.wr_en = 1'b0; period_tick = 1'b0;
    endtask

    task automatic rd(logic [3:0] a, logic [31:0] exp, string name);
        @(negedge CLK);
        bus.rd_addr = a;
        @(posedge CLK);
        #1;
        chk(name, bus.rd_data, exp);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_freq", FREQ_Cnt_Set, 32'd9999);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;

        // Shadow isolation
        add(1, 4'h0, 499, 0, 0, 9999, 0, 0);
        add(1, 4'h8, 200, 0, 0, 9999, 0, 0);
        add(1, 4'h2, 1,   0, 0, 9999, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 4'h0, 0, 1, 0, 9999, 0, 0);
        // Commit at boundary, tick 10 cycles after the commit write
        add(1, 4'h2, 3, 0, 0, 9999, 0, 1);
        for (int i = 0; i < 9; i++) add(0, 4'h0, 0, 0, 0, 9999, 0, 1);
        add(0, 4'h0, 0, 1, 0, 499, 200, 0);
        // Ramp up then down on CH1
        add(1, 4'h9, 250, 0, 1, 499, 0, 0);
        add(1, 4'h1, 100, 0, 1, 499, 0, 0);
        add(1, 4'h2, 3,   0, 1, 499, 0, 1);
        add(0, 4'h0, 0, 1, 1, 499, 100, 1);
        add(0, 4'h0, 0, 1, 1, 499, 200, 1);
        add(0, 4'h0, 0, 1, 1, 499, 250, 0);
        add(1, 4'h9, 30, 0, 1, 499, 250, 0);
        add(1, 4'h2, 3,  0, 1, 499, 250, 1);
        add(0, 4'h0, 0, 1, 1, 499, 150, 1);
        add(0, 4'h0, 0, 1, 1, 499, 50, 1);
        add(0, 4'h0, 0, 1, 1, 499, 30, 0);
        // Collision: commit on the tick, target write on the commit tick
        add(1, 4'hA, 300, 0, 2, 499, 0, 0);
        add(1, 4'h2, 3,   1, 2, 499, 0, 1);
        add(1, 4'hA, 500, 1, 2, 499, 100, 1);
        add(0, 4'h0, 0, 1, 2, 499, 200, 1);
        add(0, 4'h0, 0, 1, 2, 499, 300, 0);
        // Disable mid-ramp, then re-enable
        add(1, 4'hB, 400, 0, 3, 499, 0, 0);
        add(1, 4'h2, 3,   0, 3, 499, 0, 1);
        add(0, 4'h0, 0, 1, 3, 499, 100, 1);
        add(1, 4'h2, 0,   0, 3, 499, 100, 1);
        add(0, 4'h0, 0, 1, 3, 499, 0, 0);
        add(1, 4'h2, 1,   0, 3, 499, 0, 1);
        add(0, 4'h0, 0, 1, 3, 499, 100, 1);

        foreach (vq[i]) begin
            cycle(vq[i].we, vq[i].a, vq[i].d, vq[i].tk);
            chk($sformatf("v%0d_freq", i), FREQ_Cnt_Set, vq[i].ef);
            chk($sformatf("v%0d_ch%0d", i, vq[i].ch), ch_out[vq[i].ch], vq[i].ed);
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vq[i].eb});
        end
        chk("reen_ch0", ch_out[0], 32'd100);
        chk("reen_ch2", ch_out[2], 32'd100);

        // Readback
        rd(4'h0, 32'd499, "rd_freq_sh");
        rd(4'h1, 32'd100, "rd_step");
        rd(4'h2, 32'd5,   "rd_ctrl");
        rd(4'h3, 32'd499, "rd_freq");
        rd(4'h7, 32'd100, "rd_ch3_duty");
        rd(4'h5, 32'd30,  "rd_ch1_duty");
        rd(4'hA, 32'd500, "rd_ch2_tgt");
        rd(4'h9, 32'd30,  "rd_ch1_tgt");
        rd(4'hC, 32'd0,   "rd_ch4_tgt");

        // Asynchronous reset while pending and ramping
        cycle(1, 4'h2, 3, 0);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        @(negedge CLK);
        #2;
        RST_n = 1'b0;
        #1;
        chk("arst_freq", FREQ_Cnt_Set, 32'd9999);
        chk("arst_ch0", ch_out[0], 32'd0);
        chk("arst_ch3", ch_out[3], 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        rd(4'h2, 32'd0, "post_rst_ctrl");
        rd(4'h0, 32'd9999, "post_rst_freq_sh");
        cycle(0, 4'h0, 0, 1);
        chk("post_rst_tick_ch0", ch_out[0], 32'd0);
        chk("post_rst_tick_freq", FREQ_Cnt_Set, 32'd9999);
        chk("post_rst_tick_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
- Register-programmable configuration controller for the 8-channel PWM peripheral.
- Holds shadow copies of the period and the eight duty targets, written from the PS register bus.
- Commits them to the PWM datapath only at a period boundary, so the PWM never sees a mid-period change.
- After a commit, ramps each channel's duty toward its target by a programmable step once per PWM period (soft-start / slew limiting).

Parameters:
- DEF_FREQ, 32'd9999, period count driven on FREQ_Cnt_Set after reset.

Ports:
- CLK  input  1  system clock, shared with the PWM datapath.
- RST_n  input  1  asynchronous active-low reset.
- wr_en  input  1  register write strobe, one cycle per write.
- wr_addr  input  4  register write address.
- wr_data  input  32  register write data.
- rd_addr  input  4  register read address.
- rd_data  output  32  read data, registered.
- period_tick  input  1  one-cycle pulse in the cycle the PWM counter wraps to 0.
- FREQ_Cnt_Set  output  32  committed period count to the PWM.
- CH0_duty_Set .. CH7_duty_Set  output  32 each  active duty count to the PWM.
- busy  output  1  a commit is pending, or any channel is still ramping.

Behaviour:
- Clock and reset: single clock CLK; reset RST_n is asynchronous, active-low.
- Reset values: FREQ_Cnt_Set=DEF_FREQ; all CHx_duty_Set=0; rd_data=0; busy=0. Internally: freq_shadow=DEF_FREQ; all target shadows and committed targets=0; step=0; enable=0; pending=0.
- Reset asserted mid-ramp or mid-pending: all state returns immediately to reset values. No ramping resumes after release.
- Register map (write):
  - 0x0 freq_shadow.
  - 0x1 step.
  - 0x2 CTRL: bit0 enable, bit1 commit. Commit is write-1 to set pending and is not stored.
  - 0x8..0xF target shadow CH0..CH7.
  - Other addresses are ignored.
- Shadow writes never change any output directly.
- Commit:
  - On period_tick with pending=1: FREQ_Cnt_Set<=freq_shadow; committed target[i]<=target shadow[i]; pending<=0.
  - The values committed are the shadow contents before that cycle's write, if any.
- Write/tick collisions:
  - Commit write in the same cycle as period_tick: pending is set, but the commit happens at the next tick.
  - Commit write while already pending: no effect (stays pending).
- Ramp, evaluated per channel on every period_tick, using the committed target as updated in that same tick:
  - enable=0: duty<=0.
  - enable=1, step=0: duty<=target (immediate).
  - enable=1, duty<target: duty<=duty+min(step, target-duty).
  - enable=1, duty>target: duty<=duty-min(step, duty-target).
  - Arithmetic is unsigned 32-bit. The min() guarantees no overshoot and no wrap-around.
  - No clamping against FREQ_Cnt_Set. duty>FREQ_Cnt_Set gives 100% output in the PWM; this is intentional.
- Outputs change only in the cycle after a period_tick; there is no other update path.
- State summary (derived, reflected on busy):
  - IDLE: pending=0 and every duty equals its target (or enable=0 with all duty=0).
  - PEND: pending=1.
  - RAMP: pending=0 and some duty differs from its target.
  - IDLE->PEND on commit write; PEND->RAMP/IDLE on tick; RAMP->IDLE when the last channel reaches its target.
  - busy = pending | (any duty != (enable ? committed target : 0)).
  - busy is combinational from registered state.
- Readback: rd_data is registered, 1-cycle latency.
  - 0x0 freq_shadow; 0x1 step; 0x2 {29'b0, busy, pending, enable}; 0x3 FREQ_Cnt_Set.
  - 0x8..0xF target shadow; 0x4..0x7 return CH0..CH3 active duty; others return 0.

Test Plan:
- Reset defaults: assert RST_n=0 mid-operation -> FREQ_Cnt_Set=9999, all duty=0, busy=0 asynchronously; reading 0x2 -> 0.
- Shadow isolation: write FREQ=499, CH0 target=200, enable=1, no commit, apply 3 period_ticks -> FREQ_Cnt_Set stays 9999, CH0 stays 0, busy=0.
- Commit at boundary: write commit, then pulse period_tick 10 cycles later with step=0 -> FREQ_Cnt_Set=499 and CH0=200 exactly one cycle after the tick, busy=0 afterwards.
- Ramp up/down: step=100, commit CH1 target=250 -> CH1 is 100, 200, 250 over successive ticks, with busy=1 until 250. Then target=30 and commit -> CH1 is 150, 50, 30.
- Collision: commit write coincides with period_tick -> no output change on that tick; applied on the next tick. A target write in the commit tick is not committed.
- Disable: enable=0 during a ramp -> all duty=0 at the next tick. Re-enable -> ramp restarts from 0.
